switch_debounce_leds: RTL
=========================

# switch_debounce_leds

Parametrised, multi-channel switch-to-LED block for the Go Board. It replaces the direct switch-to-LED wiring. Each channel synchronises its raw push-button input, debounces it with a stability counter, and drives its LED in one of two modes, selected per channel:

- direct: the LED follows the debounced switch.
- toggle: each debounced press flips the LED.

The block sits between the top-level switch pins and the LED pins. It also exports debounced levels and press pulses for other logic.

## Interface

Parameters:
- NUM_CH, default 4: number of switch/LED channels (≥1).
- DEBOUNCE_LIMIT, default 250000: consecutive stable cycles required to accept a new level. The default is 10 ms at 25 MHz. Must be ≥1.
- Counter width is derived as max(1, $clog2(DEBOUNCE_LIMIT)).

Ports:
- i_Clk, input, 1: system clock; all state updates on the rising edge.
- i_Rst_L, input, 1: reset, asynchronous, active-low.
- i_Switch, input, NUM_CH: raw, asynchronous, active-high switch pins.
- i_Mode, input, NUM_CH: per-channel mode; 0 = direct, 1 = toggle. Quasi-static.
- o_LED, output, NUM_CH: LED drive, active-high.
- o_Debounced, output, NUM_CH: debounced switch level.
- o_Press, output, NUM_CH: one-cycle pulse on each debounced 0→1 transition.

## Operation

Each channel is independent. Channel state consists of:
- sync1, sync2: two-flop synchroniser.
- deb: debounced level.
- cnt: stability counter.
- tog: toggle register.
- press: registered press pulse.

Per rising edge of i_Clk:
- Synchroniser: sync1 ← i_Switch[n]; sync2 ← sync1.
- If sync2 == deb: cnt ← 0; press ← 0.
- If sync2 != deb and cnt < DEBOUNCE_LIMIT−1: cnt ← cnt+1; press ← 0.
- If sync2 != deb and cnt == DEBOUNCE_LIMIT−1: deb ← sync2; cnt ← 0.
  - press ← sync2, i.e. 1 only on a 0→1 flip.
  - tog ← tog ^ sync2, i.e. tog flips on a press, never on a release.

Outputs:
- o_Debounced[n] = deb.
- o_Press[n] = press.
- o_LED[n] = i_Mode[n] ? tog : deb. This is a combinational mux of registered values.

Behaviour details:
- tog keeps updating in both modes. Changing i_Mode switches o_LED immediately to the other register, with no reset of tog.
- Any cycle where sync2 returns to deb clears cnt. A bounce shorter than DEBOUNCE_LIMIT cycles therefore produces no output change.
- cnt never exceeds DEBOUNCE_LIMIT−1 and never wraps.
- With DEBOUNCE_LIMIT = 1, deb follows sync2 with one cycle of delay.

Reset (i_Rst_L low, asynchronous): all sync1, sync2, deb, cnt, tog and press registers clear to 0. The outputs are then:
- o_Debounced = 0.
- o_Press = 0.
- o_LED = 0 in both modes.

Reset mid-count abandons the count. After release, a held switch is re-debounced from scratch.

## Timing

Edge numbering: edge 1 is the first rising edge at which sync1 samples the new level, and the level then stays stable.
- sync2 shows the new level after edge 2.
- cnt reaches DEBOUNCE_LIMIT−1 after edge DEBOUNCE_LIMIT+1.
- deb, tog and press update at edge DEBOUNCE_LIMIT+2.
- Total latency from pin to o_LED, o_Debounced and o_Press is DEBOUNCE_LIMIT+2 cycles.
- o_Press is high for exactly one cycle per press.
- Release: same latency for o_Debounced and for direct-mode o_LED. o_Press stays 0. Toggle-mode o_LED is unchanged.
- Simultaneous activity on several channels is handled independently and with identical latency.
- No handshake is involved. Outputs are valid every cycle after reset release.

## Test plan

All scenarios use NUM_CH=4 and DEBOUNCE_LIMIT=4.

- Reset values: hold i_Rst_L low, with i_Switch=4'hF and i_Mode=4'h3. Required: o_LED, o_Debounced and o_Press all 4'h0, asynchronously and throughout reset.
- Direct press and release: ch0 in direct mode; raise i_Switch[0] before edge 1 and hold it. Required: o_LED[0] and o_Debounced[0] rise at edge 6, and o_Press[0] is high for edge 6 to 7 only. Drop the switch: o_LED[0] falls 6 edges later and o_Press stays 0.
- Bounce rejection: ch1 toggles 1,0,1,0 with each level held 3 cycles, then settles at 1. Required: no output change during the bouncing, o_Debounced[1] rises 6 edges after the final settle, and exactly one o_Press[1] pulse occurs.
- Toggle mode: ch2 with i_Mode[2]=1; perform three clean press/release pairs. Required: o_LED[2] sequence 0→1→0→1, each change 6 edges after its press, with no change on any release.
- Mode switch: ch3 with one press in toggle mode (tog=1) and the switch released. Set i_Mode[3]=0. Required: o_LED[3] shows 0 immediately. Restore i_Mode[3]=1: o_LED[3] shows 1 immediately.
- Reset mid-count: hold ch0 high and assert i_Rst_L after cnt=2, then release reset. Required: all outputs 0 during reset, and o_Debounced[0] rises 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/switch_debounce_leds.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce_leds
// Brief    : Per-channel switch synchroniser + debouncer driving LEDs in
//            direct (follow) or toggle (flip on press) mode.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debounce_leds #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic [NUM_CH-1:0] i_Mode,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Debounced,
    output logic [NUM_CH-1:0] o_Press
);

    localparam int                 c_CNT_W   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_LIMIT - 1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic               sync1_q, sync2_q;
        logic               deb_q, deb_d;
        logic               tog_q, tog_d;
        logic               press_q, press_d;
        logic [c_CNT_W-1:0] cnt_q, cnt_d;

        // Any cycle where the synchronised level agrees with deb restarts the count.
        always_comb begin
            deb_d   = deb_q;
            tog_d   = tog_q;
            press_d = 1'b0;
            cnt_d   = '0;
            if (sync2_q != deb_q) begin
                if (cnt_q == c_CNT_MAX) begin
                    deb_d   = sync2_q;
                    press_d = sync2_q;
                    tog_d   = tog_q ^ sync2_q;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
        end

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                deb_q   <= 1'b0;
                tog_q   <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= i_Switch[g];
                sync2_q <= sync1_q;
                deb_q   <= deb_d;
                tog_q   <= tog_d;
                press_q <= press_d;
                cnt_q   <= cnt_d;
            end
        end

        assign o_Debounced[g] = deb_q;
        assign o_Press[g]     = press_q;
        assign o_LED[g]       = i_Mode[g] ? tog_q : deb_q;
    end

endmodule
`default_nettype wire
